// File: rtl/rail_pwr_sequencer.sv
// Shared-rail power sequencer: grants block power switches one ramp at a time, caps
// concurrently powered blocks, and holds a discharge settle period after power-down.
// Optional macro PG_CHECK_EN: power-good check at end of ramp and while ON, with sticky fault.
module rail_pwr_sequencer #(
    parameter int NUM_BLK     = 3,
    parameter int RAMP_CYCLES = 16,
    parameter int OFF_CYCLES  = 8,
    parameter int MAX_ON      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BLK-1:0]             req,
    input  logic [NUM_BLK-1:0]             pg_in,
    output logic [NUM_BLK-1:0]             sw_en,
    output logic [NUM_BLK-1:0]             pwr_ok,
    output logic [NUM_BLK-1:0]             fault,
    output logic                           busy,
    output logic [$clog2(NUM_BLK+1)-1:0]   on_cnt
);

    localparam int CW = $clog2(NUM_BLK + 1);
    localparam int PW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam int RW = $clog2(RAMP_CYCLES);
    localparam int DW = (OFF_CYCLES > 1) ? $clog2(OFF_CYCLES) : 1;

    localparam logic [CW-1:0] MAX_ON_C  = CW'(MAX_ON);
    localparam logic [RW-1:0] RAMP_LOAD = RW'(RAMP_CYCLES - 1);
    localparam logic [DW-1:0] DRN_LOAD  = DW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(NUM_BLK - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAIT,
        S_RAMP,
        S_ON,
        S_DRAIN,
        S_FAULT
    } state_e;

    state_e             st_q  [NUM_BLK];
    state_e             st_d  [NUM_BLK];
    logic [DW-1:0]      drn_q [NUM_BLK];
    logic [DW-1:0]      drn_d [NUM_BLK];
    logic [RW-1:0]      ramp_q, ramp_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_BLK-1:0] sw_en_q, sw_en_d;
    logic [NUM_BLK-1:0] pwr_ok_q, pwr_ok_d;
    logic [NUM_BLK-1:0] fault_q, fault_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      on_cnt_q, on_cnt_d;

    logic [NUM_BLK-1:0] cand;
    logic [NUM_BLK-1:0] gnt;
    logic               slot_free;
    logic               found;

`ifndef PG_CHECK_EN
    logic unused_pg;
    assign unused_pg = ^pg_in;
`endif

    // Registered busy/on_cnt mirror the current state, so the slot check sees last cycle's state.
    always_comb begin
        cand      = '0;
        gnt       = '0;
        found     = 1'b0;
        ptr_d     = ptr_q;
        slot_free = !busy_q && (on_cnt_q < MAX_ON_C);
        for (int i = 0; i < NUM_BLK; i++) begin
            cand[i] = (st_q[i] == S_WAIT) && req[i];
        end
        if (slot_free) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                if (!found && cand[i] && (i > int'(ptr_q))) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    ptr_d  = PW'(i);
                end
            end
            for (int i = 0; i < NUM_BLK; i++) begin
                if (!found && cand[i]) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    ptr_d  = PW'(i);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BLK; i++) begin
            st_d[i]  = st_q[i];
            drn_d[i] = drn_q[i];
            case (st_q[i])
                S_OFF: begin
                    if (req[i]) st_d[i] = S_WAIT;
                end
                S_WAIT: begin
                    if (!req[i])     st_d[i] = S_OFF;
                    else if (gnt[i]) st_d[i] = S_RAMP;
                end
                S_RAMP: begin
                    if (!req[i]) begin
                        st_d[i]  = S_DRAIN;
                        drn_d[i] = DRN_LOAD;
                    end else if (ramp_q == '0) begin
`ifdef PG_CHECK_EN
                        st_d[i] = pg_in[i] ? S_ON : S_FAULT;
`else
                        st_d[i] = S_ON;
`endif
                    end
                end
                S_ON: begin
                    if (!req[i]) begin
                        st_d[i]  = S_DRAIN;
                        drn_d[i] = DRN_LOAD;
                    end
`ifdef PG_CHECK_EN
                    else if (!pg_in[i]) begin
                        st_d[i] = S_FAULT;
                    end
`endif
                end
                S_DRAIN: begin
                    if (drn_q[i] == '0) st_d[i]  = S_OFF;
                    else                drn_d[i] = drn_q[i] - DW'(1);
                end
                S_FAULT: begin
                    if (!req[i]) st_d[i] = S_OFF;
                end
                default: st_d[i] = S_OFF;
            endcase
        end
    end

    // One shared ramp counter suffices because at most one block ramps at a time.
    always_comb begin
        ramp_d = ramp_q;
        if (|gnt)               ramp_d = RAMP_LOAD;
        else if (ramp_q != '0)  ramp_d = ramp_q - RW'(1);
    end

    always_comb begin
        sw_en_d  = '0;
        pwr_ok_d = '0;
        fault_d  = '0;
        busy_d   = 1'b0;
        on_cnt_d = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            sw_en_d[i]  = (st_d[i] == S_RAMP) || (st_d[i] == S_ON);
            pwr_ok_d[i] = (st_d[i] == S_ON);
`ifdef PG_CHECK_EN
            fault_d[i]  = (st_d[i] == S_FAULT);
`endif
            if (st_d[i] == S_RAMP) busy_d = 1'b1;
            if (sw_en_d[i])        on_cnt_d = on_cnt_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                st_q[i]  <= S_OFF;
                drn_q[i] <= '0;
            end
            ramp_q   <= '0;
            ptr_q    <= PTR_RST;
            sw_en_q  <= '0;
            pwr_ok_q <= '0;
            fault_q  <= '0;
            busy_q   <= 1'b0;
            on_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BLK; i++) begin
                st_q[i]  <= st_d[i];
                drn_q[i] <= drn_d[i];
            end
            ramp_q   <= ramp_d;
            ptr_q    <= ptr_d;
            sw_en_q  <= sw_en_d;
            pwr_ok_q <= pwr_ok_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            on_cnt_q <= on_cnt_d;
        end
    end

    assign sw_en  = sw_en_q;
    assign pwr_ok = pwr_ok_q;
    assign fault  = fault_q;
    assign busy   = busy_q;
    assign on_cnt = on_cnt_q;

endmodule

// File: tb/tb_rail_pwr_sequencer.sv
// Bench for rail_pwr_sequencer (default parameters): vector table with a scoreboard queue,
// plus a hand-written latency / ramp-length sequence.
module tb_rail_pwr_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] pg_in;
    logic [2:0] sw_en;
    logic [2:0] pwr_ok;
    logic [2:0] fault;
    logic       busy;
    logic [1:0] on_cnt;

    always #5 clk = ~clk;

    rail_pwr_sequencer #(
        .NUM_BLK    (3),
        .RAMP_CYCLES(16),
        .OFF_CYCLES (8),
        .MAX_ON     (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pg_in (pg_in),
        .sw_en (sw_en),
        .pwr_ok(pwr_ok),
        .fault (fault),
        .busy  (busy),
        .on_cnt(on_cnt)
    );

`ifdef PG_CHECK_EN
    localparam bit PG = 1'b1;
`else
    localparam bit PG = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] pg;
        int         n;
        logic [2:0] sw;
        logic [2:0] pok;
        logic [2:0] flt;
        logic       bsy;
        logic [1:0] on;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic add(input logic r, input logic [2:0] rq, input logic [2:0] pg, input int n,
                       input logic [2:0] sw, input logic [2:0] pok, input logic [2:0] flt,
                       input logic b, input logic [1:0] on);
        vec_t v;
        v.rst = r; v.req = rq; v.pg = pg; v.n = n;
        v.sw = sw; v.pok = pok; v.flt = flt; v.bsy = b; v.on = on;
        vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else begin
            $display("%s ok: %0d", name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_v;
        logic [11:0] act_v;
        int          cyc;
        int          bcnt;

        rst = 1'b1; req = 3'b000; pg_in = 3'b111;

        // basic ramp, then drop and immediately re-request: 8-cycle drain before re-grant
        add(1, 3'b000, 3'b111,  2, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b100, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b100, 3'b111,  1, 3'b100, 3'b000, 3'b000, 1, 2'd1);
        add(0, 3'b100, 3'b111, 15, 3'b100, 3'b000, 3'b000, 1, 2'd1);
        add(0, 3'b100, 3'b111,  1, 3'b100, 3'b100, 3'b000, 0, 2'd1);
        add(0, 3'b000, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b100, 3'b111,  9, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b100, 3'b111,  1, 3'b100, 3'b000, 3'b000, 1, 2'd1);
        // all three request; MAX_ON=2 holds block 2 until block 0 drops
        add(1, 3'b000, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b111, 3'b111,  2, 3'b001, 3'b000, 3'b000, 1, 2'd1);
        add(0, 3'b111, 3'b111, 16, 3'b001, 3'b001, 3'b000, 0, 2'd1);
        add(0, 3'b111, 3'b111,  1, 3'b011, 3'b001, 3'b000, 1, 2'd2);
        add(0, 3'b111, 3'b111, 16, 3'b011, 3'b011, 3'b000, 0, 2'd2);
        add(0, 3'b111, 3'b111,  3, 3'b011, 3'b011, 3'b000, 0, 2'd2);
        add(0, 3'b110, 3'b111,  1, 3'b010, 3'b010, 3'b000, 0, 2'd1);
        add(0, 3'b110, 3'b111,  1, 3'b110, 3'b010, 3'b000, 1, 2'd2);
        // abort block 1 at ramp cycle 5, then reset while block 0 ON / block 1 RAMP
        add(1, 3'b000, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b111, 3'b111, 19, 3'b011, 3'b001, 3'b000, 1, 2'd2);
        add(0, 3'b111, 3'b111,  4, 3'b011, 3'b001, 3'b000, 1, 2'd2);
        add(0, 3'b101, 3'b111,  1, 3'b001, 3'b001, 3'b000, 0, 2'd1);
        add(0, 3'b101, 3'b111,  1, 3'b101, 3'b001, 3'b000, 1, 2'd2);
        add(0, 3'b111, 3'b111,  1, 3'b101, 3'b001, 3'b000, 1, 2'd2);
        add(1, 3'b111, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b111, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b111, 3'b111,  1, 3'b001, 3'b000, 3'b000, 1, 2'd1);
        add(0, 3'b111, 3'b111, 19, 3'b011, 3'b001, 3'b000, 1, 2'd2);
        add(1, 3'b111, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b111, 3'b111,  2, 3'b001, 3'b000, 3'b000, 1, 2'd1);
        // pointer=0 with WAIT={0,2}: block 2 wins first
        add(1, 3'b000, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b001, 3'b111, 18, 3'b001, 3'b001, 3'b000, 0, 2'd1);
        add(0, 3'b000, 3'b111,  9, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b101, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b101, 3'b111,  1, 3'b100, 3'b000, 3'b000, 1, 2'd1);
        add(0, 3'b101, 3'b111, 16, 3'b100, 3'b100, 3'b000, 0, 2'd1);
        add(0, 3'b101, 3'b111,  1, 3'b101, 3'b100, 3'b000, 1, 2'd2);
        // power-good low on block 0 at end of ramp
        add(1, 3'b000, 3'b111,  1, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        add(0, 3'b011, 3'b110, 17, 3'b001, 3'b000, 3'b000, 1, 2'd1);
        add(0, 3'b011, 3'b110,  1, PG ? 3'b000 : 3'b001, PG ? 3'b000 : 3'b001,
            PG ? 3'b001 : 3'b000, 0, PG ? 2'd0 : 2'd1);
        add(0, 3'b011, 3'b110,  1, PG ? 3'b010 : 3'b011, PG ? 3'b000 : 3'b001,
            PG ? 3'b001 : 3'b000, 1, PG ? 2'd1 : 2'd2);
        add(0, 3'b011, 3'b110,  5, PG ? 3'b010 : 3'b011, PG ? 3'b000 : 3'b001,
            PG ? 3'b001 : 3'b000, 1, PG ? 2'd1 : 2'd2);
        add(0, 3'b010, 3'b110,  1, 3'b010, 3'b000, 3'b000, 1, 2'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            rst   = vecs[k].rst;
            req   = vecs[k].req;
            pg_in = vecs[k].pg;
            sb_q.push_back({vecs[k].sw, vecs[k].pok, vecs[k].flt, vecs[k].bsy, vecs[k].on});
            repeat (vecs[k].n) @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            act_v = {sw_en, pwr_ok, fault, busy, on_cnt};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL vec%0d sw/pok/flt/busy/on: got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, act_v[11:9], act_v[8:6], act_v[5:3], act_v[2], act_v[1:0],
                         exp_v[11:9], exp_v[8:6], exp_v[5:3], exp_v[2], exp_v[1:0]);
            end else begin
                $display("vec%0d ok sw=%b pok=%b flt=%b busy=%b on=%0d",
                         k, act_v[11:9], act_v[8:6], act_v[5:3], act_v[2], act_v[1:0]);
            end
        end

        // latency from req sampled to sw_en, ramp length and pwr_ok timing
        rst = 1'b1; req = 3'b000; pg_in = 3'b111;
        @(posedge clk); #1;
        rst = 1'b0; req = 3'b010;
        cyc = 0;
        while (!sw_en[1] && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_int("lat_sw_en", cyc, 2);
        bcnt = 0;
        while (busy && bcnt < 40) begin
            bcnt++;
            @(posedge clk); #1;
        end
        check_int("busy_len", bcnt, 16);
        check_int("pwr_ok_at_ramp_end", int'(pwr_ok[1]), 1);
        check_int("on_cnt_after_ramp", int'(on_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
